// File: rtl/fse_spi_pkg.sv
// Shared types and constants for the FSE LMS serial configuration port initiator.
package fse_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_SHIFT = 3'd2,
      ST_HOLD  = 3'd3,
      ST_GAP   = 3'd4
   } spi_state_e;

   localparam int unsigned SPI_CPOL    = 0;
   localparam int unsigned SPI_CPHA    = 0;
   localparam int unsigned SPI_FRAME_W = 16;

endpackage

// File: rtl/fse_spi_tick.sv
// Half-period timer: ticks every CLK_DIV enabled cycles after a clear.
module fse_spi_tick
   import fse_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int unsigned   CW     = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   assign tick = en && (r_cnt == '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cnt <= RELOAD;
      end else if (clr || tick) begin
         r_cnt <= RELOAD;
      end else if (en) begin
         r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/fse_spi_master.sv
// SPI mode-0 initiator: one MSB-first frame per request, response returned with a done pulse.
module fse_spi_master
   import fse_spi_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned DATA_W  = SPI_FRAME_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              spi_ss_n_o,
   output logic              spi_sclk_o,
   output logic              spi_mosi_o,
   input  logic              spi_miso_i
);

   localparam int unsigned   BW        = $clog2(DATA_W + 1);
   localparam logic [BW-1:0] LAST_FALL = BW'(DATA_W - 1);
   localparam logic [BW-1:0] ALL_FALLS = BW'(DATA_W);
   localparam logic          SCLK_IDLE = SPI_CPOL[0];

   generate
      if (CLK_DIV < 1) begin : g_bad_div
         $error("fse_spi_master: CLK_DIV must be >= 1");
      end
      if (DATA_W < 2) begin : g_bad_width
         $error("fse_spi_master: DATA_W must be >= 2");
      end
   endgenerate

   spi_state_e        r_state;
   logic [DATA_W-2:0] r_tx;
   logic [DATA_W-1:0] r_rx;
   logic [DATA_W-1:0] r_rx_data;
   logic [BW-1:0]     r_bitcnt;
   logic              r_sclk;
   logic              r_mosi;
   logic              r_ss_n;
   logic              r_busy;
   logic              r_done;
   logic              w_tick;
   logic              w_en;
   logic              w_accept;

   assign w_en     = (r_state != ST_IDLE);
   // A request seen as GAP expires is taken on that edge, so held start_i gives back-to-back frames.
   assign w_accept = start_i && ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_tick));

   fse_spi_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr    (w_accept),
      .en     (w_en),
      .tick   (w_tick)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= ST_IDLE;
         r_tx      <= '0;
         r_rx      <= '0;
         r_rx_data <= '0;
         r_bitcnt  <= '0;
         r_sclk    <= SCLK_IDLE;
         r_mosi    <= 1'b0;
         r_ss_n    <= 1'b1;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_state  <= ST_SETUP;
            r_tx     <= tx_data_i[DATA_W-2:0];
            r_mosi   <= tx_data_i[DATA_W-1];
            r_rx     <= '0;
            r_bitcnt <= '0;
            r_sclk   <= SCLK_IDLE;
            r_ss_n   <= 1'b0;
            r_busy   <= 1'b1;
         end else if (w_tick) begin
            case (r_state)
               ST_SETUP: begin
                  r_state <= ST_SHIFT;
                  r_sclk  <= 1'b1;
                  r_rx    <= {r_rx[DATA_W-2:0], spi_miso_i};
               end
               ST_SHIFT: begin
                  // One idle half-period follows the last fall before HOLD begins.
                  if (r_bitcnt == ALL_FALLS) begin
                     r_state <= ST_HOLD;
                  end else if (!r_sclk) begin
                     r_sclk <= 1'b1;
                     r_rx   <= {r_rx[DATA_W-2:0], spi_miso_i};
                  end else begin
                     r_sclk   <= 1'b0;
                     r_bitcnt <= r_bitcnt + BW'(1);
                     r_mosi   <= (r_bitcnt == LAST_FALL) ? 1'b0 : r_tx[DATA_W-2];
                     r_tx     <= r_tx << 1;
                  end
               end
               ST_HOLD: begin
                  r_state   <= ST_GAP;
                  r_ss_n    <= 1'b1;
                  r_rx_data <= r_rx;
                  r_done    <= 1'b1;
               end
               ST_GAP: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign rx_data_o  = r_rx_data;
   assign spi_ss_n_o = r_ss_n;
   assign spi_sclk_o = r_sclk;
   assign spi_mosi_o = r_mosi;

endmodule

// File: tb/tb_fse_spi_master.sv
// Directed bench for fse_spi_master: default 16-bit instance plus a CLK_DIV=1, 2-bit instance.
module tb_fse_spi_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start_a = 1'b0;
   logic [15:0] tx_a = '0;
   logic        busy_a, done_a, ss_a, sclk_a, mosi_a, miso_a;
   logic [15:0] rx_a;
   logic        loop_mode = 1'b1;

   logic        start_b = 1'b0;
   logic [1:0]  tx_b = '0;
   logic        busy_b, done_b, ss_b, sclk_b, mosi_b;
   logic [1:0]  rx_b;

   int n_vec = 0;
   int n_err = 0;

   // observer results for DUT A
   int rises, done_cnt, done1_at, done2_at, idle_at, ss_fall_at, ss_high, stab_viol;

   // behavioural mode-0 slave
   logic [15:0] slave_word = 16'h1234;
   logic [15:0] s_rx = '0;
   int          s_fall = 0;
   logic        s_armed = 1'b0;
   logic        s_miso;

   always #5 clk = ~clk;

   fse_spi_master #(.CLK_DIV(2), .DATA_W(16)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .tx_data_i(tx_a),
      .busy_o(busy_a), .done_o(done_a), .rx_data_o(rx_a),
      .spi_ss_n_o(ss_a), .spi_sclk_o(sclk_a), .spi_mosi_o(mosi_a), .spi_miso_i(miso_a)
   );

   fse_spi_master #(.CLK_DIV(1), .DATA_W(2)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .tx_data_i(tx_b),
      .busy_o(busy_b), .done_o(done_b), .rx_data_o(rx_b),
      .spi_ss_n_o(ss_b), .spi_sclk_o(sclk_b), .spi_mosi_o(mosi_b), .spi_miso_i(mosi_b)
   );

   always @(negedge sclk_a or negedge ss_a or posedge ss_a) begin
      if (ss_a) s_armed <= 1'b0;
      else if (!s_armed) begin s_armed <= 1'b1; s_fall <= 0; end
      else s_fall <= s_fall + 1;
   end

   always @(posedge sclk_a or negedge ss_a) begin
      if (sclk_a) s_rx <= {s_rx[14:0], mosi_a};
      else        s_rx <= '0;
   end

   assign s_miso = (s_fall < 16) ? slave_word[15 - s_fall] : 1'b0;
   assign miso_a = loop_mode ? mosi_a : s_miso;

   task automatic do_accept(input logic [15:0] d, input logic keep);
      @(negedge clk);
      tx_a = d; start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep) start_a = 1'b0;
   endtask

   // Cycle-by-cycle observer; sample n is taken half a clock after edge E0+n.
   task automatic watch(input int ncyc, input int pulse_at, input logic drop_on_refall);
      logic p_sclk, p_mosi, p_ss;
      rises = 0; done_cnt = 0; done1_at = -1; done2_at = -1; idle_at = -1;
      ss_fall_at = -1; ss_high = 0; stab_viol = 0;
      p_sclk = sclk_a; p_mosi = mosi_a; p_ss = ss_a;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         if (sclk_a && !p_sclk) begin
            rises++;
            if (mosi_a !== p_mosi) stab_viol++;
         end
         if (done_a) begin
            done_cnt++;
            if (done1_at < 0) done1_at = n;
            else if (done2_at < 0) done2_at = n;
         end
         if (!busy_a && idle_at < 0) idle_at = n;
         if (ss_a && ss_fall_at < 0) ss_high++;
         if (!ss_a && p_ss && ss_fall_at < 0) begin
            ss_fall_at = n;
            if (drop_on_refall) start_a = 1'b0;
         end
         if (n == pulse_at) begin start_a = 1'b1; tx_a = 16'hFFFF; end
         else if (n == pulse_at + 1) start_a = 1'b0;
         p_sclk = sclk_a; p_mosi = mosi_a; p_ss = ss_a;
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_vec++; if (ss_a !== 1'b1)    begin n_err++; $display("FAIL rst_ss: got %b want 1", ss_a); end
      n_vec++; if (sclk_a !== 1'b0)  begin n_err++; $display("FAIL rst_sclk: got %b want 0", sclk_a); end
      n_vec++; if (mosi_a !== 1'b0)  begin n_err++; $display("FAIL rst_mosi: got %b want 0", mosi_a); end
      n_vec++; if (busy_a !== 1'b0)  begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      n_vec++; if (done_a !== 1'b0)  begin n_err++; $display("FAIL rst_done: got %b want 0", done_a); end
      n_vec++; if (rx_a !== 16'h0)   begin n_err++; $display("FAIL rst_rx: got %h want 0000", rx_a); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_loopback;
      loop_mode = 1'b1;
      do_accept(16'hA5C3, 1'b0);
      n_vec++; if (ss_a !== 1'b0)   begin n_err++; $display("FAIL lb_accept_ss: got %b want 0", ss_a); end
      n_vec++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL lb_accept_busy: got %b want 1", busy_a); end
      n_vec++; if (mosi_a !== 1'b1) begin n_err++; $display("FAIL lb_accept_mosi: got %b want 1", mosi_a); end
      watch(80, -10, 1'b0);
      n_vec++; if (rises !== 16)     begin n_err++; $display("FAIL lb_rises: got %0d want 16", rises); end
      n_vec++; if (done1_at !== 68)  begin n_err++; $display("FAIL lb_done_at: got %0d want 68", done1_at); end
      n_vec++; if (done_cnt !== 1)   begin n_err++; $display("FAIL lb_done_cnt: got %0d want 1", done_cnt); end
      n_vec++; if (rx_a !== 16'hA5C3) begin n_err++; $display("FAIL lb_rx: got %h want a5c3", rx_a); end
      n_vec++; if (idle_at !== 70)   begin n_err++; $display("FAIL lb_idle_at: got %0d want 70", idle_at); end
   endtask

   task automatic test_slave;
      loop_mode = 1'b0;
      do_accept(16'hBEEF, 1'b0);
      watch(80, -10, 1'b0);
      n_vec++; if (s_rx !== 16'hBEEF) begin n_err++; $display("FAIL sl_slave_rx: got %h want beef", s_rx); end
      n_vec++; if (rx_a !== 16'h1234) begin n_err++; $display("FAIL sl_rx: got %h want 1234", rx_a); end
      n_vec++; if (stab_viol !== 0)   begin n_err++; $display("FAIL sl_mosi_stable: got %0d want 0", stab_viol); end
      n_vec++; if (rises !== 16)      begin n_err++; $display("FAIL sl_rises: got %0d want 16", rises); end
      loop_mode = 1'b1;
   endtask

   task automatic test_ignore_busy;
      loop_mode = 1'b1;
      do_accept(16'h5A3C, 1'b0);
      watch(80, 10, 1'b0);
      n_vec++; if (done_cnt !== 1)    begin n_err++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
      n_vec++; if (done1_at !== 68)   begin n_err++; $display("FAIL ign_done_at: got %0d want 68", done1_at); end
      n_vec++; if (rx_a !== 16'h5A3C) begin n_err++; $display("FAIL ign_rx: got %h want 5a3c", rx_a); end
   endtask

   task automatic test_back_to_back;
      loop_mode = 1'b1;
      do_accept(16'h0F0F, 1'b1);
      watch(150, -10, 1'b1);
      n_vec++; if (done1_at !== 68)   begin n_err++; $display("FAIL b2b_done1: got %0d want 68", done1_at); end
      n_vec++; if (done2_at !== 138)  begin n_err++; $display("FAIL b2b_done2: got %0d want 138", done2_at); end
      n_vec++; if (ss_fall_at !== 70) begin n_err++; $display("FAIL b2b_accept2: got %0d want 70", ss_fall_at); end
      n_vec++; if (ss_high !== 2)     begin n_err++; $display("FAIL b2b_ss_gap: got %0d want 2", ss_high); end
      n_vec++; if (done_cnt !== 2)    begin n_err++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt); end
      n_vec++; if (idle_at !== 140)   begin n_err++; $display("FAIL b2b_idle_at: got %0d want 140", idle_at); end
      n_vec++; if (rx_a !== 16'h0F0F) begin n_err++; $display("FAIL b2b_rx: got %h want 0f0f", rx_a); end
   endtask

   task automatic test_reset_midframe;
      int seen_done;
      loop_mode = 1'b1;
      do_accept(16'h9669, 1'b0);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (ss_a !== 1'b1)   begin n_err++; $display("FAIL mid_ss: got %b want 1", ss_a); end
      n_vec++; if (sclk_a !== 1'b0) begin n_err++; $display("FAIL mid_sclk: got %b want 0", sclk_a); end
      n_vec++; if (mosi_a !== 1'b0) begin n_err++; $display("FAIL mid_mosi: got %b want 0", mosi_a); end
      n_vec++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy_a); end
      n_vec++; if (rx_a !== 16'h0)  begin n_err++; $display("FAIL mid_rx: got %h want 0000", rx_a); end
      seen_done = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done_a) seen_done++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done_a) seen_done++;
      end
      n_vec++; if (seen_done !== 0) begin n_err++; $display("FAIL mid_no_done: got %0d want 0", seen_done); end
      do_accept(16'h3C96, 1'b0);
      watch(80, -10, 1'b0);
      n_vec++; if (done1_at !== 68)   begin n_err++; $display("FAIL mid_re_done: got %0d want 68", done1_at); end
      n_vec++; if (rx_a !== 16'h3C96) begin n_err++; $display("FAIL mid_re_rx: got %h want 3c96", rx_a); end
   endtask

   task automatic test_small;
      int d_at, d_cnt;
      logic [1:0] pat;
      pat = 2'b10;
      d_at = -1; d_cnt = 0;
      @(negedge clk);
      tx_b = pat; start_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_b = 1'b0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (done_b) begin d_cnt++; if (d_at < 0) d_at = n; end
      end
      n_vec++; if (d_at !== 6)     begin n_err++; $display("FAIL small_done_at: got %0d want 6", d_at); end
      n_vec++; if (d_cnt !== 1)    begin n_err++; $display("FAIL small_done_cnt: got %0d want 1", d_cnt); end
      n_vec++; if (rx_b !== 2'b10) begin n_err++; $display("FAIL small_rx: got %b want 10", rx_b); end
      n_vec++; if (busy_b !== 1'b0) begin n_err++; $display("FAIL small_idle: got %b want 0", busy_b); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_slave();
      test_ignore_busy();
      test_back_to_back();
      test_reset_midframe();
      test_small();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
